mux1: RTL and testbench

//   2:1 selector: output y follows x0 when s=0 and x1 when s=1, combinationally.

---
 rtl/mux1.sv | 50 +++++
 tb/tb_mux1.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux1.sv
// 2:1 data selector with a registered copy of the result, a registered select
// and a saturating count of edges on which the select differed from its registered value.
module mux1 #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             s_q,
  output logic [CNT_W-1:0] sw_cnt
);

  logic [WIDTH-1:0] y_reg_d, y_reg_q;
  logic             s_reg_d, s_reg_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Ternary keeps X-select semantics: bits where x0 and x1 agree stay known.
  assign y = s ? x1 : x0;

  always_comb begin
    y_reg_d = y;
    s_reg_d = s;
    cnt_d   = cnt_q;
    if ((s != s_reg_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg_q <= '0;
      s_reg_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      y_reg_q <= y_reg_d;
      s_reg_q <= s_reg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y_q    = y_reg_q;
  assign s_q    = s_reg_q;
  assign sw_cnt = cnt_q;

endmodule

// File: tb/tb_mux1.sv
// Self-checking bench for mux1: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a behavioural model.
module tb_mux1;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst;
  logic [7:0] x0, x1;
  logic       s;

  logic       y_a, yq_a, sq_a;
  logic [7:0] cnt_a;
  logic [7:0] y_b, yq_b;
  logic       sq_b;
  logic [1:0] cnt_b;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state
  logic       m_yq_a, m_sq;
  logic [7:0] m_yq_b;
  int         m_cnt_a, m_cnt_b;

  always #5 clk = clk_en ? ~clk : clk;

  mux1 #(.WIDTH(1), .CNT_W(8)) u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .x0     (x0[0]),
    .x1     (x1[0]),
    .s      (s),
    .y      (y_a),
    .y_q    (yq_a),
    .s_q    (sq_a),
    .sw_cnt (cnt_a)
  );

  mux1 #(.WIDTH(8), .CNT_W(2)) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .x0     (x0),
    .x1     (x1),
    .s      (s),
    .y      (y_b),
    .y_q    (yq_b),
    .s_q    (sq_b),
    .sw_cnt (cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: registered copies and saturating toggle counts.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_yq_a  <= 1'b0;
      m_yq_b  <= 8'h00;
      m_sq    <= 1'b0;
      m_cnt_a <= 0;
      m_cnt_b <= 0;
    end else begin
      m_yq_a  <= s ? x1[0] : x0[0];
      m_yq_b  <= s ? x1 : x0;
      m_sq    <= s;
      m_cnt_a <= (s != m_sq) ? ((m_cnt_a + 1 > 255) ? 255 : m_cnt_a + 1) : m_cnt_a;
      m_cnt_b <= (s != m_sq) ? ((m_cnt_b + 1 > 3) ? 3 : m_cnt_b + 1) : m_cnt_b;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("y_a",    {31'b0, y_a},   {31'b0, s ? x1[0] : x0[0]});
      chk("y_b",    {24'b0, y_b},   {24'b0, s ? x1 : x0});
      chk("yq_a",   {31'b0, yq_a},  {31'b0, m_yq_a});
      chk("yq_b",   {24'b0, yq_b},  {24'b0, m_yq_b});
      chk("sq_a",   {31'b0, sq_a},  {31'b0, m_sq});
      chk("sq_b",   {31'b0, sq_b},  {31'b0, m_sq});
      chk("cnt_a",  {24'b0, cnt_a}, 32'(m_cnt_a));
      chk("cnt_b",  {30'b0, cnt_b}, 32'(m_cnt_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] tt;
    tt  = 8'b1101_1000;  // bit {x0,x1,s} holds expected y
    rst = 1'b1;
    x0  = 8'h00;
    x1  = 8'h00;
    s   = 1'b0;

    // Exhaustive combinational check under reset, no clock
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx   = 3'(i);
      x0[0] = idx[2];
      x1[0] = idx[1];
      s     = idx[0];
      #1;
      chk("tt_y", {31'b0, y_a}, {31'b0, tt[idx]});
      #9;
    end
    chk("rst_yq",  {31'b0, yq_a},  32'd0);
    chk("rst_sq",  {31'b0, sq_a},  32'd0);
    chk("rst_cnt", {24'b0, cnt_a}, 32'd0);

    // Registered path
    x0 = 8'h00; x1 = 8'h01; s = 1'b0;
    clk_en = 1'b1;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("reg_yq0", {31'b0, yq_a}, 32'd0);
    s = 1'b1;
    #1;
    chk("reg_y_now", {31'b0, y_a}, 32'd1);
    chk("reg_yq_hold", {31'b0, yq_a}, 32'd0);
    tick();
    chk("reg_yq1", {31'b0, yq_a}, 32'd1);
    chk("reg_sq1", {31'b0, sq_a}, 32'd1);

    // Toggle count and hold
    s = 1'b0;
    rst_pulse();
    for (int i = 0; i < 5; i++) begin
      s = ~s;
      tick();
    end
    chk("tog_cnt5", {24'b0, cnt_a}, 32'd5);
    chk("tog_sat_b", {30'b0, cnt_b}, 32'd3);
    for (int i = 0; i < 3; i++) tick();
    chk("hold_cnt5", {24'b0, cnt_a}, 32'd5);

    // Saturation on the narrow counter
    s = 1'b0;
    rst_pulse();
    for (int i = 0; i < 6; i++) begin
      s = ~s;
      tick();
      if (i >= 2) chk("sat_b", {30'b0, cnt_b}, 32'd3);
    end
    chk("sat_a6", {24'b0, cnt_a}, 32'd6);

    // Async reset between edges
    s = 1'b0;
    x0 = 8'hFF; x1 = 8'hFF;
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      s = ~s;
      tick();
    end
    chk("pre_yq1",  {31'b0, yq_a},  32'd1);
    chk("pre_cnt4", {24'b0, cnt_a}, 32'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_yq",  {31'b0, yq_a},  32'd0);
    chk("arst_sq",  {31'b0, sq_a},  32'd0);
    chk("arst_cnt", {24'b0, cnt_a}, 32'd0);
    chk("arst_y",   {31'b0, y_a},   32'd1);
    rst = 1'b0;
    tick();

    // Wide data
    x0 = 8'hA5; x1 = 8'h3C; s = 1'b0;
    #1;
    chk("wide_y0", {24'b0, y_b}, 32'h0000_00A5);
    tick();
    chk("wide_yq0", {24'b0, yq_b}, 32'h0000_00A5);
    s = 1'b1;
    #1;
    chk("wide_y1", {24'b0, y_b}, 32'h0000_003C);
    chk("wide_yq_hold", {24'b0, yq_b}, 32'h0000_00A5);
    tick();
    chk("wide_yq1", {24'b0, yq_b}, 32'h0000_003C);

    // Randomized phase with occasional asynchronous reset pulses
    for (int i = 0; i < 400; i++) begin
      x0 = 8'($urandom);
      x1 = 8'($urandom);
      s  = 1'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
